// File: rtl/axis_frame_reader_pkg.sv
// axis_frame_reader_pkg: shared FSM state type and sizing helpers for the RX frame reader
package axis_frame_reader_pkg;
  typedef enum logic [1:0] {FILL, DROP, HOLD} state_t;
  localparam int DEF_WORD_WIDTH = 64;
  localparam int DEF_MAX_BYTES = 2048;
  function automatic int bytes_per_word(input int ww);
    return ww / 8;
  endfunction
  function automatic int len_width(input int mb);
    return $clog2(mb) + 1;
  endfunction
endpackage

// File: rtl/axis_frame_reader_if.sv
// axis_frame_reader_if: byte-wide AXI-stream bundle
// master drives tdata/tvalid/tlast/tuser, slave drives tready
interface axis_frame_reader_if #(parameter int USER_WIDTH = 1) ();
  logic [7:0]            tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_reader_mem.sv
// frame_buf_mem: 1R1W frame buffer with registered synchronous read
// ports: clk; i_we/i_waddr/i_wdata write; i_re/i_raddr read; o_rdata holds until the next i_re
module frame_buf_mem #(
  parameter int WIDTH = 64,
  parameter int ELS   = 256
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [$clog2(ELS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_re,
  input  logic [$clog2(ELS)-1:0] i_raddr,
  output logic [WIDTH-1:0]       o_rdata
);
  logic [WIDTH-1:0] r_mem [ELS];
  logic [WIDTH-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/axis_frame_reader.sv
// axis_frame_reader: packs byte AXI-stream frames into a word buffer, holds one good frame for host reads
// ports: clk, rst_n (sync active-low); s_axis stream slave; frame_v_o/frame_len_o held frame;
// rd_v_i/rd_addr_i/rd_data_o word read; pop_i release; drop_count_o/bad_count_o saturating stats
module axis_frame_reader import axis_frame_reader_pkg::*; #(
  parameter int                    WORD_WIDTH           = DEF_WORD_WIDTH,
  parameter int                    MAX_BYTES            = DEF_MAX_BYTES,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int                    CNT_WIDTH            = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  axis_frame_reader_if.slave                        s_axis,
  output logic                                      frame_v_o,
  output logic [$clog2(MAX_BYTES):0]                frame_len_o,
  input  logic                                      rd_v_i,
  input  logic [$clog2(MAX_BYTES*8/WORD_WIDTH)-1:0] rd_addr_i,
  output logic [WORD_WIDTH-1:0]                     rd_data_o,
  input  logic                                      pop_i,
  output logic [CNT_WIDTH-1:0]                      drop_count_o,
  output logic [CNT_WIDTH-1:0]                      bad_count_o
);
  localparam int BPW = bytes_per_word(WORD_WIDTH);
  localparam int LW  = len_width(MAX_BYTES);
  localparam int AW  = $clog2(MAX_BYTES / BPW);
  state_t                r_state;
  logic                  r_tready;
  logic                  r_fv;
  logic [LW-1:0]         r_n;
  logic [LW-1:0]         r_len;
  logic [WORD_WIDTH-1:0] r_stage;
  logic [CNT_WIDTH-1:0]  r_drop;
  logic [CNT_WIDTH-1:0]  r_bad;
  logic                  w_acc;
  logic                  w_fill;
  logic                  w_over;
  logic                  w_bad;
  logic                  w_we;
  logic [LW-1:0]         w_lane;
  logic [WORD_WIDTH-1:0] w_word;
  logic [AW-1:0]         w_waddr;
  assign w_acc   = s_axis.tvalid & r_tready;
  assign w_fill  = w_acc && r_state == FILL;
  assign w_over  = r_n == LW'(MAX_BYTES);
  assign w_lane  = r_n % LW'(BPW);
  // staging is cleared after every word write, so lanes above the newest byte are already zero
  assign w_word  = r_stage | (WORD_WIDTH'(s_axis.tdata) << {w_lane, 3'b000});
  assign w_we    = w_fill && !w_over && (w_lane == LW'(BPW - 1) || s_axis.tlast);
  assign w_waddr = AW'(r_n / LW'(BPW));
  assign w_bad   = |(USER_BAD_FRAME_MASK & ~(s_axis.tuser ^ USER_BAD_FRAME_VALUE));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= FILL;
      r_tready <= 1'b0;
      r_fv     <= 1'b0;
      r_n      <= '0;
      r_len    <= '0;
      r_stage  <= '0;
      r_drop   <= '0;
      r_bad    <= '0;
    end else begin
      r_tready <= 1'b1;
      if (w_we) r_stage <= '0;
      else if (w_fill && !w_over) r_stage <= w_word;
      case (r_state)
        FILL: if (w_acc) begin
          if (w_over) begin
            if (s_axis.tlast) begin
              r_n <= '0;
              if (!(&r_drop)) r_drop <= r_drop + 1'b1;
            end else r_state <= DROP;
          end else if (s_axis.tlast) begin
            r_n <= '0;
            if (w_bad) begin
              if (!(&r_bad)) r_bad <= r_bad + 1'b1;
            end else begin
              r_len    <= r_n + 1'b1;
              r_fv     <= 1'b1;
              r_tready <= 1'b0;
              r_state  <= HOLD;
            end
          end else r_n <= r_n + 1'b1;
        end
        DROP: if (w_acc && s_axis.tlast) begin
          r_n     <= '0;
          r_state <= FILL;
          if (!(&r_drop)) r_drop <= r_drop + 1'b1;
        end
        HOLD: if (pop_i) begin
          r_fv    <= 1'b0;
          r_state <= FILL;
        end else r_tready <= 1'b0;
        default: r_state <= FILL;
      endcase
    end
  end
  frame_buf_mem #(.WIDTH(WORD_WIDTH), .ELS(MAX_BYTES / BPW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_word),
    .i_re    (rd_v_i),
    .i_raddr (rd_addr_i),
    .o_rdata (rd_data_o)
  );
  assign s_axis.tready = r_tready;
  assign frame_v_o     = r_fv;
  assign frame_len_o   = r_len;
  assign drop_count_o  = r_drop;
  assign bad_count_o   = r_bad;
endmodule

// File: tb/tb_axis_frame_reader.sv
// tb_axis_frame_reader: directed frames checked every cycle against a queue-based frame model
module tb_axis_frame_reader;
  localparam int WW  = 64;
  localparam int MB  = 2048;
  localparam int BPW = WW / 8;
  localparam int AW  = $clog2(MB * 8 / WW);
  localparam int LW  = $clog2(MB) + 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_v = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          pop = 1'b0;
  logic          fv, fv2;
  logic [LW-1:0] len, len2;
  logic [WW-1:0] rd_data, rd_data2;
  logic [15:0]   drop, bad;
  logic [1:0]    drop2, bad2;
  int checks = 0;
  int errors = 0;
  axis_frame_reader_if #(.USER_WIDTH(1)) s_if ();
  axis_frame_reader_if #(.USER_WIDTH(1)) s_if2 ();
  assign s_if2.tdata  = s_if.tdata;
  assign s_if2.tvalid = s_if.tvalid;
  assign s_if2.tlast  = s_if.tlast;
  assign s_if2.tuser  = s_if.tuser;
  always #5 clk = ~clk;
  axis_frame_reader dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .frame_v_o(fv), .frame_len_o(len),
    .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .pop_i(pop),
    .drop_count_o(drop), .bad_count_o(bad)
  );
  axis_frame_reader #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if2), .frame_v_o(fv2), .frame_len_o(len2),
    .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_data_o(rd_data2), .pop_i(pop),
    .drop_count_o(drop2), .bad_count_o(bad2)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic int sat(input int v, input int max);
    return v < max ? v + 1 : v;
  endfunction
  logic         m_held, m_dropping, m_rdy, m_rdchk;
  int           m_len, m_drop, m_bad, m_drop2, m_bad2;
  logic [7:0]   m_q[$];
  logic [7:0]   m_buf[MB];
  logic [WW-1:0] m_rdexp;
  always @(posedge clk) begin
    m_rdchk = 1'b0;
    if (!rst_n) begin
      m_held = 0; m_dropping = 0; m_rdy = 0; m_len = 0;
      m_drop = 0; m_bad = 0; m_drop2 = 0; m_bad2 = 0;
      m_q.delete();
    end else begin
      if (rd_v && m_held && int'(rd_addr) * BPW < m_len) begin
        m_rdchk = 1'b1;
        m_rdexp = '0;
        for (int k = 0; k < BPW; k++)
          if (int'(rd_addr) * BPW + k < m_len) m_rdexp[k*8 +: 8] = m_buf[int'(rd_addr) * BPW + k];
      end
      if (m_held) begin
        if (pop) m_held = 0;
      end else if (s_if.tvalid && m_rdy) begin
        if (m_dropping) begin
          if (s_if.tlast) begin
            m_dropping = 0; m_drop = sat(m_drop, 65535); m_drop2 = sat(m_drop2, 3);
          end
        end else if (m_q.size() == MB) begin
          m_q.delete();
          if (s_if.tlast) begin
            m_drop = sat(m_drop, 65535); m_drop2 = sat(m_drop2, 3);
          end else m_dropping = 1;
        end else begin
          m_q.push_back(s_if.tdata);
          if (s_if.tlast) begin
            if (s_if.tuser == 1'b1) begin
              m_bad = sat(m_bad, 65535); m_bad2 = sat(m_bad2, 3);
            end else begin
              m_held = 1;
              m_len = m_q.size();
              for (int i = 0; i < m_q.size(); i++) m_buf[i] = m_q[i];
            end
            m_q.delete();
          end
        end
      end
      m_rdy = !m_held;
    end
    #1;
    chk("tready", s_if.tready, m_rdy);
    chk("frame_v", fv, m_held);
    chk("frame_len", len, m_len);
    chk("drop_count", drop, m_drop);
    chk("bad_count", bad, m_bad);
    chk("drop_count_w2", drop2, m_drop2);
    chk("bad_count_w2", bad2, m_bad2);
    if (m_rdchk) chk("rd_data", rd_data, m_rdexp);
  end
  task automatic send(input int n, input int upto, input logic [7:0] base, input logic user);
    for (int i = 0; i < upto; i++) begin
      logic r;
      int t;
      s_if.tvalid = 1'b1;
      s_if.tdata  = base + 8'(i);
      s_if.tlast  = (i == n - 1);
      s_if.tuser  = (i == n - 1) ? user : 1'b0;
      t = 0;
      do begin
        r = s_if.tready;
        @(negedge clk);
        t++;
      end while (!r && t < 500);
      if (!r) chk("accept_timeout", r, 1);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask
  task automatic wait_fv();
    int t = 0;
    while (!fv && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!fv) chk("frame_v_timeout", fv, 1);
  endtask
  task automatic rd(input int a);
    rd_v = 1'b1;
    rd_addr = AW'(a);
    @(negedge clk);
    rd_v = 1'b0;
  endtask
  task automatic do_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_frame_v", fv, 0);
    chk("rst_len", len, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", s_if.tready, 1);
    send(13, 13, 8'h01, 1'b0);
    wait_fv();
    chk("t1_len", len, 13);
    rd(0);
    chk("t1_word0", rd_data, 64'h0807060504030201);
    rd(1);
    chk("t1_word1", rd_data, 64'h0000000D0C0B0A09);
    do_pop();
    chk("t1_popped", fv, 0);
    send(5, 5, 8'h30, 1'b1);
    @(negedge clk);
    chk("t2_bad", bad, 1);
    chk("t2_fv", fv, 0);
    send(8, 8, 8'h50, 1'b0);
    wait_fv();
    rd(0);
    chk("t2_word0", rd_data, 64'h5756555453525150);
    do_pop();
    send(MB + 3, MB + 3, 8'h00, 1'b0);
    @(negedge clk);
    chk("t3_drop", drop, 1);
    chk("t3_fv", fv, 0);
    send(MB, MB, 8'h80, 1'b0);
    wait_fv();
    chk("t3_len", len, MB);
    rd(MB / BPW - 1);
    chk("t3_lastword", rd_data, 64'h7F7E7D7C7B7A7978);
    do_pop();
    fork
      begin
        send(6, 6, 8'h20, 1'b0);
        send(10, 10, 8'h40, 1'b0);
      end
      begin
        wait_fv();
        rd(0);
        chk("t4_a_word0", rd_data, 64'h0000252423222120);
        repeat (49) @(negedge clk);
        chk("t4_tready_hold", s_if.tready, 0);
        do_pop();
      end
    join
    wait_fv();
    chk("t4_len", len, 10);
    rd(0);
    chk("t4_b_word0", rd_data, 64'h4746454443424140);
    rd(1);
    chk("t4_b_word1", rd_data, 64'h0000000000004948);
    do_pop();
    send(20, 7, 8'hA0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_drop", drop, 0);
    chk("t5_bad", bad, 0);
    chk("t5_fv", fv, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(4, 4, 8'hC0, 1'b0);
    wait_fv();
    chk("t5_len", len, 4);
    rd(0);
    chk("t5_word0", rd_data, 64'h00000000C3C2C1C0);
    do_pop();
    for (int f = 0; f < 5; f++) send(3, 3, 8'hE0 + 8'(f * 4), 1'b1);
    @(negedge clk);
    chk("t6_bad_sat", bad2, 3);
    chk("t6_bad_wide", bad, 5);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
